// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared constants and types for the 8-way round-robin arbiter.
package mux8_rr_arbiter_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;
  localparam int CNT_W = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  function automatic logic [N_REQ-1:0] onehot8(input logic [SEL_W-1:0] i);
    return {{(N_REQ-1){1'b0}}, 1'b1} << i;
  endfunction

endpackage

// File: rtl/mux8_rr_arbiter_rr_pick8.sv
// Rotating priority encoder: first set req bit at or after ptr, wrapping mod 8.
module rr_pick8
  import mux8_rr_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] pos;

  // Scan from the far end back toward ptr so the closest hit wins last.
  always_comb begin
    idx = ptr;
    pos = ptr;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      pos = ptr + SEL_W'(i);
      if (req[pos]) idx = pos;
    end
    any = |req;
  end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter/sequencer for mux_8: picks a winner, drives sel, meters beats via valid/ready.
module mux8_rr_arbiter
  import mux8_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             out_ready,
  output logic [SEL_W-1:0] sel,
  output logic [N_REQ-1:0] gnt,
  output logic             out_valid,
  output logic [N_REQ-1:0] ack,
  output logic             busy
);

  // Handshake: a beat transfers in any cycle where out_valid & out_ready are both high;
  // out_valid follows req[sel] combinationally during GRANT and is never forced.
  arb_state_e       state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic             pick_any;
  logic [SEL_W-1:0] pick_idx;
  logic             accept;

  rr_pick8 u_pick (
    .req (req),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      sel_q      <= '0;
      gnt_q      <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      sel_q      <= sel_d;
      gnt_q      <= gnt_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    sel_d      = sel_q;
    gnt_d      = gnt_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d    = ST_GRANT;
          sel_d      = pick_idx;
          gnt_d      = onehot8(pick_idx);
          beat_cnt_d = '0;
        end
      end
      ST_GRANT: begin
        // Withdrawal and last-beat both release; sel is kept for the bubble cycle.
        if (!req[sel_q] || (accept && beat_cnt_q == CNT_W'(MAX_HOLD - 1))) begin
          state_d    = ST_IDLE;
          ptr_d      = sel_q + SEL_W'(1);
          gnt_d      = '0;
          beat_cnt_d = '0;
        end else if (accept) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state_q == ST_GRANT) && req[sel_q];
    accept    = out_valid && out_ready;
    ack       = gnt_q & {N_REQ{accept}};
    busy      = (state_q == ST_GRANT);
    sel       = sel_q;
    gnt       = gnt_q;
  end

endmodule
